// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Producer side of the register-file write port. Each cycle one result is picked
//   for writing: an ALU result if present, otherwise the oldest buffered load result.
//   Load results are held in a small FIFO. A pending-write scoreboard lets the issue
//   logic detect RAW hazards on two source registers.
//
// Ports
//   clk, nReset               clock (rising edge), asynchronous active-low reset
//   flush                     synchronous: empty the load FIFO, clear the scoreboard,
//                             discard this cycle's ALU result and issue
//   issueValid, issueDst      issued instruction with a destination (marks pending)
//   aluValid, aluDst, aluData ALU result, always accepted
//   loadValid, loadReady,     load result, valid/ready handshake into the FIFO
//   loadDst, loadData
//   srcA, srcB                registers queried for hazards
//   hazardA, hazardB          combinational pending flags (0 for x0)
//   we, dst, inData           registered write port to the register file
//   loadCount                 FIFO occupancy
module regfile_writeback #(
    parameter int WordSize  = 32,
    parameter int LoadDepth = 4
) (
    input  logic                         clk,
    input  logic                         nReset,
    input  logic                         flush,
    input  logic                         issueValid,
    input  logic [4:0]                   issueDst,
    input  logic                         aluValid,
    input  logic [4:0]                   aluDst,
    input  logic [WordSize-1:0]          aluData,
    input  logic                         loadValid,
    output logic                         loadReady,
    input  logic [4:0]                   loadDst,
    input  logic [WordSize-1:0]          loadData,
    input  logic [4:0]                   srcA,
    input  logic [4:0]                   srcB,
    output logic                         hazardA,
    output logic                         hazardB,
    output logic                         we,
    output logic [4:0]                   dst,
    output logic [WordSize-1:0]          inData,
    output logic [$clog2(LoadDepth):0]   loadCount
);

    localparam int PW = $clog2(LoadDepth);
    localparam int CW = PW + 1;

    logic [4:0]          dstq  [LoadDepth];
    logic [WordSize-1:0] dataq [LoadDepth];
    logic [PW-1:0]       wrPtr;
    logic [PW-1:0]       rdPtr;
    logic [CW-1:0]       count;
    logic [31:1]         pending;
    logic [31:0]         pendVec;
    logic [31:0]         pendNext;

    logic                accept;
    logic                pop;
    logic                fifoNonEmpty;
    logic                selValid_p0;
    logic [4:0]          selDst_p0;
    logic [WordSize-1:0] selData_p0;
    logic                selWrite_p0;

    // Readiness depends only on occupancy; a same-edge pop does not free a slot early.
    assign loadReady    = (count < CW'(LoadDepth));
    assign loadCount    = count;
    assign fifoNonEmpty = (count != '0);
    assign accept       = loadValid && loadReady && !flush;
    // An ALU result (even to x0) blocks the drain; the FIFO only drains when idle.
    assign pop          = !flush && !aluValid && fifoNonEmpty;

    always_comb begin
        selValid_p0 = 1'b0;
        selDst_p0   = '0;
        selData_p0  = '0;
        if (!flush) begin
            if (aluValid) begin
                selValid_p0 = 1'b1;
                selDst_p0   = aluDst;
                selData_p0  = aluData;
            end else if (fifoNonEmpty) begin
                selValid_p0 = 1'b1;
                selDst_p0   = dstq[rdPtr];
                selData_p0  = dataq[rdPtr];
            end
        end
    end

    // x0 writes are selected (and popped) but never reach the register file.
    assign selWrite_p0 = selValid_p0 && (selDst_p0 != 5'd0);

    // Bit 0 is tied low so x0 queries and updates need no special indexing.
    assign pendVec = {pending, 1'b0};
    assign hazardA = pendVec[srcA];
    assign hazardB = pendVec[srcB];

    // Clear first, then set: a same-edge issue to the written register wins.
    always_comb begin
        pendNext = pendVec;
        if (flush) begin
            pendNext = '0;
        end else begin
            if (selWrite_p0)
                pendNext[selDst_p0] = 1'b0;
            if (issueValid && (issueDst != 5'd0))
                pendNext[issueDst] = 1'b1;
        end
        pendNext[0] = 1'b0;
    end

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            dstq[wrPtr]  <= loadDst;
            dataq[wrPtr] <= loadData;
        end
    end

    // Stage p0 -> p1: register the selected write and update queue/scoreboard state.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            pending <= '0;
            we      <= 1'b0;
            dst     <= '0;
            inData  <= '0;
        end else begin
            pending <= pendNext[31:1];
            we      <= selWrite_p0;
            if (selValid_p0) begin
                dst    <= selDst_p0;
                inData <= selData_p0;
            end
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (accept)
                    wrPtr <= wrPtr + 1'b1;
                if (pop)
                    rdPtr <= rdPtr + 1'b1;
                case ({accept, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          flush, issueValid, aluValid, loadValid;
    logic [4:0]    issueDst, aluDst, loadDst, srcA, srcB;
    logic [W-1:0]  aluData, loadData;
    logic          loadReady, hazardA, hazardB, we;
    logic [4:0]    dst;
    logic [W-1:0]  inData;
    logic [CW-1:0] loadCount;

    always #5 clk = ~clk;

    regfile_writeback #(.WordSize(W), .LoadDepth(D)) dut (
        .clk(clk), .nReset(nReset), .flush(flush),
        .issueValid(issueValid), .issueDst(issueDst),
        .aluValid(aluValid), .aluDst(aluDst), .aluData(aluData),
        .loadValid(loadValid), .loadReady(loadReady), .loadDst(loadDst), .loadData(loadData),
        .srcA(srcA), .srcB(srcB), .hazardA(hazardA), .hazardB(hazardB),
        .we(we), .dst(dst), .inData(inData), .loadCount(loadCount)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of pending loads, a set of pending registers, and the
    // last write presented to the register file.
    typedef struct packed { logic [4:0] d; logic [W-1:0] v; } entry_t;
    entry_t       q[$];
    bit   [31:0]  pend;
    bit           mwe;
    logic [4:0]   mdst;
    logic [W-1:0] mdata;

    task automatic model_reset();
        q.delete();
        pend  = '0;
        mwe   = 1'b0;
        mdst  = '0;
        mdata = '0;
    endtask

    task automatic model_edge();
        bit         room;
        bit         sel;
        entry_t     s;
        if (flush) begin
            q.delete();
            pend = '0;
            mwe  = 1'b0;
            return;
        end
        room = (q.size() < D);
        sel  = 1'b0;
        s    = '0;
        if (aluValid) begin
            sel = 1'b1; s.d = aluDst; s.v = aluData;
        end else if (q.size() > 0) begin
            sel = 1'b1; s = q.pop_front();
        end
        if (loadValid && room) q.push_back({loadDst, loadData});
        mwe = sel && (s.d != 0);
        if (sel) begin mdst = s.d; mdata = s.v; end
        if (mwe) pend[s.d] = 1'b0;
        if (issueValid && issueDst != 0) pend[issueDst] = 1'b1;
    endtask

    task automatic compare();
        check("we", 64'(we), 64'(mwe));
        if (mwe) begin
            check("dst", 64'(dst), 64'(mdst));
            check("inData", 64'(inData), 64'(mdata));
        end
        check("loadCount", 64'(loadCount), 64'(q.size()));
        check("loadReady", 64'(loadReady), 64'(q.size() < D));
        check("hazardA", 64'(hazardA), 64'(srcA != 0 && pend[srcA]));
        check("hazardB", 64'(hazardB), 64'(srcB != 0 && pend[srcB]));
    endtask

    // Inputs are changed after the falling edge; outputs are compared just before the
    // rising edge, then the model advances with the same inputs.
    task automatic step();
        #1 compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; issueValid = 0; issueDst = 0; aluValid = 0; aluDst = 0; aluData = 0;
        loadValid = 0; loadDst = 0; loadData = 0; srcA = 0; srcB = 0;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        #1 model_reset();
        check("rst_we", 64'(we), 64'd0);
        check("rst_dst", 64'(dst), 64'd0);
        check("rst_inData", 64'(inData), 64'd0);
        check("rst_loadCount", 64'(loadCount), 64'd0);
        check("rst_loadReady", 64'(loadReady), 64'd1);
        check("rst_hazardA", 64'(hazardA), 64'd0);
        check("rst_hazardB", 64'(hazardB), 64'd0);
        @(negedge clk);
        nReset = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // ALU priority over a same-cycle load
        aluValid = 1; aluDst = 5; aluData = 32'hAAAA;
        loadValid = 1; loadDst = 6; loadData = 32'hBBBB;
        step();
        idle();
        #1;
        check("prio_we1", 64'(we), 64'd1);
        check("prio_dst1", 64'(dst), 64'd5);
        check("prio_data1", 64'(inData), 64'hAAAA);
        step();
        #1;
        check("prio_we2", 64'(we), 64'd1);
        check("prio_dst2", 64'(dst), 64'd6);
        check("prio_data2", 64'(inData), 64'hBBBB);
        step();

        // Backpressure: ALU held, 5 loads offered, 4 accepted
        for (int i = 0; i < 5; i++) begin
            aluValid = 1; aluDst = 5'(1 + i); aluData = 32'(i);
            loadValid = 1; loadDst = 5'(10 + i); loadData = 32'(100 + i);
            step();
        end
        idle();
        aluValid = 1; aluDst = 1;
        #1;
        check("bp_count", 64'(loadCount), 64'd4);
        check("bp_ready", 64'(loadReady), 64'd0);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            check("drain_dst", 64'(dst), 64'(10 + i));
            check("drain_data", 64'(inData), 64'(100 + i));
        end
        step();

        // Scoreboard set/clear and same-edge set-wins
        issueValid = 1; issueDst = 7;
        step();
        idle(); srcA = 7;
        #1 check("sb_set", 64'(hazardA), 64'd1);
        aluValid = 1; aluDst = 7; aluData = 32'h77;
        step();
        aluValid = 0;
        #1 check("sb_clear", 64'(hazardA), 64'd0);
        issueValid = 1; issueDst = 7; aluValid = 1; aluDst = 7;
        step();
        idle(); srcA = 7;
        #1 check("sb_setwins", 64'(hazardA), 64'd1);
        aluValid = 1; aluDst = 7;
        step();
        idle();

        // x0 handling
        aluValid = 1; aluDst = 0; aluData = 32'hDEAD;
        issueValid = 1; issueDst = 0;
        step();
        idle();
        #1 check("x0_we", 64'(we), 64'd0);
        check("x0_haz", 64'(hazardA), 64'd0);
        step();

        // Flush with queued loads, pending regs and a same-cycle ALU result
        for (int i = 0; i < 3; i++) begin
            aluValid = 1; aluDst = 5'(20 + i); aluData = 32'(i);
            loadValid = 1; loadDst = 5'(3 + i); loadData = 32'(i);
            issueValid = (i < 2); issueDst = 5'(3 + i);
            step();
        end
        idle();
        srcA = 3; srcB = 4;
        #1 check("fl_pre", 64'(hazardA & hazardB), 64'd1);
        flush = 1; aluValid = 1; aluDst = 9; aluData = 32'h99;
        step();
        idle(); srcA = 3; srcB = 4;
        #1;
        check("fl_count", 64'(loadCount), 64'd0);
        check("fl_we", 64'(we), 64'd0);
        check("fl_hazA", 64'(hazardA), 64'd0);
        check("fl_hazB", 64'(hazardB), 64'd0);
        step();

        // Randomized traffic with occasional mid-traffic resets
        for (int n = 0; n < 3000; n++) begin
            flush      = ($urandom_range(0, 31) == 0);
            issueValid = $urandom_range(0, 1);
            issueDst   = 5'($urandom_range(0, 7));
            aluValid   = ($urandom_range(0, 2) == 0);
            aluDst     = 5'($urandom_range(0, 7));
            aluData    = $urandom;
            loadValid  = $urandom_range(0, 1);
            loadDst    = 5'($urandom_range(0, 7));
            loadData   = $urandom;
            srcA       = 5'($urandom_range(0, 7));
            srcB       = 5'($urandom_range(0, 7));
            if (n % 700 == 699) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
